led_matrix_scan: RTL and testbench
==================================

LED_MATRIX_SCAN -- requirements
Module: led_matrix_scan

Interface
REQ-001 Parameter CLK_DIV, default 4: system clocks per half-period of ser_clk; legal range 1..255.
REQ-002 Parameter ROW_HOLD, default 1000: clocks each row is lit (oe_n low); legal range 1..65535.
REQ-003 clk  input  1  single system clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 frame_valid  input  1  producer asserts while frame_data holds a complete 16x24 frame.
REQ-006 frame_data  input  384  frame image; bit index = row*24 + col; row 0..15, col 0..23; 1 = LED on.
REQ-007 frame_ready  output  1  block can accept a frame this cycle.
REQ-008 ser_data  output  1  column serial data to the panel shift register.
REQ-009 ser_clk  output  1  panel shift clock; panel samples ser_data on its rising edge.
REQ-010 ser_latch  output  1  one-clock pulse transferring shifted columns to the panel drivers.
REQ-011 row_sel  output  4  index of the row being driven.
REQ-012 oe_n  output  1  active-low panel output enable.
REQ-013 frame_done  output  1  one-clock pulse at the end of row 15 display.

Function
REQ-014 Handshake: a frame transfers on any rising edge where frame_valid and frame_ready are both 1; frame_data is captured whole in that cycle.
REQ-015 FSM states are IDLE, SHIFT, LATCH and DISPLAY.
REQ-016 IDLE: oe_n=1, ser_clk=0; the FSM leaves IDLE for SHIFT of row 0 on the cycle after the first accepted frame.
REQ-017 SHIFT: 24 bits of the current row, col 23 first, col 0 last.
REQ-018 SHIFT timing: ser_data is updated only while ser_clk=0; ser_clk toggles every CLK_DIV clocks.
REQ-019 SHIFT length is exactly 24 rising ser_clk edges; it ends with ser_clk=0 after 48*CLK_DIV clocks.
REQ-020 LATCH lasts 1 clock: ser_latch=1, oe_n=1, row_sel updates to the current row in the same cycle.
REQ-021 DISPLAY: oe_n=0 for exactly ROW_HOLD clocks, ser_clk=0, ser_latch=0.
REQ-022 After DISPLAY the row index increments and the FSM enters SHIFT.
REQ-023 Row wrap: after row 15 the row index wraps to 0; frame_done pulses on the last DISPLAY clock of row 15.
REQ-024 oe_n is 1 in every cycle of SHIFT, LATCH and IDLE (no ghosting).
REQ-025 Row period is 48*CLK_DIV + 1 + ROW_HOLD clocks; frame period is 16 times the row period.
REQ-026 A newly accepted frame is never displayed partially: the active buffer changes only when SHIFT of row 0 begins.
REQ-027 Counters are sized for the parameter maxima; no counter wraps within a state.

Reset
REQ-028 On rst_n=0, immediately and regardless of clk: state=IDLE, ser_data=0, ser_clk=0, ser_latch=0, row_sel=0, oe_n=1, frame_done=0.
REQ-029 On rst_n=0, all frame buffers and pending flags are cleared.
REQ-030 frame_ready after reset is as defined in REQ-032/REQ-033.
REQ-031 Reset asserted mid-SHIFT or mid-DISPLAY aborts the frame; after release the block waits in IDLE for a new frame.

Configuration
REQ-032 With LMS_DOUBLE_BUFFER_EN defined:
- Frames are captured into a shadow buffer and a pending flag is set.
- frame_ready=1 in every cycle outside reset; a later frame overwrites a pending one (last wins).
- At row-0 SHIFT start, if pending: shadow is copied to active and pending is cleared.
REQ-033 Without LMS_DOUBLE_BUFFER_EN:
- There is a single active buffer.
- frame_ready=1 only in IDLE or during the DISPLAY of row 15.
- A captured frame takes effect from the next row 0.

Verification (CLK_DIV=1, ROW_HOLD=4; row period 53 clocks, frame period 848 clocks)
REQ-034 Reset release with no frame, run 1000 clocks -> IDLE held: oe_n=1, ser_clk=0, frame_ready=1.
REQ-035 Load a frame with only bit 0 set (row 0, col 0) -> row 0 ser_data=1 only on the 24th ser_clk rise; ser_latch at clock 49 of the row; oe_n low 4 clocks; other rows shift all zeros.
REQ-036 Run 2 frames -> row_sel sequence 0..15,0..15; frame_done pulses exactly every 848 clocks.
REQ-037 rst_n pulsed low mid-SHIFT of row 7 -> all outputs take reset values asynchronously, with no further ser_clk edges; after release the block stays in IDLE until the next frame.
REQ-038 Double-buffered: push frame A, then frames B and C during row 5 -> rows 5..15 still show A; next frame shows C; B is never displayed.
REQ-039 Single-buffer: frame_valid held from row 3 -> frame_ready=0 until row 15 DISPLAY; handshake completes there; the new frame appears from row 0.

Source files
------------

// File: rtl/led_matrix_scan_if.sv
// Frame handshake between an image producer (master) and led_matrix_scan (slave).
interface led_matrix_scan_if;
  logic         frame_valid;
  logic [383:0] frame_data;
  logic         frame_ready;

  modport master (
    output frame_valid,
    output frame_data,
    input  frame_ready
  );

  modport slave (
    input  frame_valid,
    input  frame_data,
    output frame_ready
  );
endinterface

// File: rtl/led_matrix_scan.sv
// 16x24 LED panel scanner: per row, serial column shift, latch, then timed display.
// Optional LMS_DOUBLE_BUFFER_EN adds a shadow frame buffer so frame_ready stays high.
module led_matrix_scan #(
  parameter int unsigned CLK_DIV  = 4,
  parameter int unsigned ROW_HOLD = 1000
) (
  input  logic             clk,
  input  logic             rst_n,
  led_matrix_scan_if.slave frame_if,
  output logic             ser_data,
  output logic             ser_clk,
  output logic             ser_latch,
  output logic [3:0]       row_sel,
  output logic             oe_n,
  output logic             frame_done
);

  typedef enum logic [1:0] {IDLE, SHIFT, LATCH, DISPLAY} state_t;

  localparam logic [7:0]  DIV_LAST  = 8'(CLK_DIV - 1);
  localparam logic [15:0] HOLD_LAST = 16'(ROW_HOLD - 1);
  localparam logic [5:0]  HALF_LAST = 6'd47;

  state_t       state, state_nxt;
  logic [7:0]   div_cnt, div_cnt_nxt;
  logic [5:0]   half, half_nxt;
  logic [15:0]  hold_cnt, hold_cnt_nxt;
  logic [3:0]   row, row_nxt;
  logic [383:0] active;
  logic         pending;
  logic         accept;
  logic         row0_start;
  logic         latch_enter;
  logic [8:0]   bit_idx;

`ifdef LMS_DOUBLE_BUFFER_EN
  assign frame_if.frame_ready = rst_n;
`else
  assign frame_if.frame_ready = rst_n & ((state == IDLE) | ((state == DISPLAY) & (row == 4'd15)));
`endif

  assign accept = frame_if.frame_valid & frame_if.frame_ready;

  always_comb begin
    state_nxt    = state;
    div_cnt_nxt  = div_cnt;
    half_nxt     = half;
    hold_cnt_nxt = hold_cnt;
    row_nxt      = row;
    row0_start   = 1'b0;
    latch_enter  = 1'b0;
    frame_done   = 1'b0;
    unique case (state)
      IDLE: begin
        if (pending) begin
          state_nxt   = SHIFT;
          row_nxt     = '0;
          div_cnt_nxt = '0;
          half_nxt    = '0;
          row0_start  = 1'b1;
        end
      end
      SHIFT: begin
        // half counts ser_clk half-periods: bit = half/2, ser_clk = half[0]
        if (div_cnt == DIV_LAST) begin
          div_cnt_nxt = '0;
          if (half == HALF_LAST) begin
            state_nxt   = LATCH;
            latch_enter = 1'b1;
          end else begin
            half_nxt = half + 6'd1;
          end
        end else begin
          div_cnt_nxt = div_cnt + 8'd1;
        end
      end
      LATCH: begin
        state_nxt    = DISPLAY;
        hold_cnt_nxt = '0;
      end
      DISPLAY: begin
        if (hold_cnt == HOLD_LAST) begin
          state_nxt   = SHIFT;
          row_nxt     = row + 4'd1;
          div_cnt_nxt = '0;
          half_nxt    = '0;
          row0_start  = (row == 4'd15);
          frame_done  = (row == 4'd15);
        end else begin
          hold_cnt_nxt = hold_cnt + 16'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      div_cnt  <= '0;
      half     <= '0;
      hold_cnt <= '0;
      row      <= '0;
    end else begin
      state    <= state_nxt;
      div_cnt  <= div_cnt_nxt;
      half     <= half_nxt;
      hold_cnt <= hold_cnt_nxt;
      row      <= row_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_sel <= '0;
    end else if (latch_enter) begin
      row_sel <= row;
    end
  end

  // Column 23 goes out first, so the bit index counts down through the row.
  assign bit_idx   = 9'(row) * 9'd24 + 9'd23 - 9'(half[5:1]);
  assign ser_clk   = (state == SHIFT) & half[0];
  assign ser_data  = (state == SHIFT) & active[bit_idx];
  assign ser_latch = (state == LATCH);
  assign oe_n      = (state != DISPLAY);

`ifdef LMS_DOUBLE_BUFFER_EN
  logic [383:0] shadow;

  // A capture on the row-0 start edge lands in shadow for the following frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active  <= '0;
      shadow  <= '0;
      pending <= 1'b0;
    end else begin
      if (row0_start && pending) begin
        active <= shadow;
      end
      if (accept) begin
        shadow  <= frame_if.frame_data;
        pending <= 1'b1;
      end else if (row0_start) begin
        pending <= 1'b0;
      end
    end
  end
`else
  // Single buffer: writes only happen while no row is being shifted out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active  <= '0;
      pending <= 1'b0;
    end else begin
      if (accept) begin
        active  <= frame_if.frame_data;
        pending <= 1'b1;
      end else if (row0_start) begin
        pending <= 1'b0;
      end
    end
  end
`endif

endmodule

// File: tb/tb_led_matrix_scan.sv
// Bench for led_matrix_scan: position-in-frame reference model checked every cycle,
// plus literal checks of row timing, handshake blocking, buffering and async reset.
`timescale 1ns/1ps
module tb_led_matrix_scan;

  localparam int D         = 1;
  localparam int H         = 4;
  localparam int SHIFT_LEN = 48 * D;
  localparam int RP        = SHIFT_LEN + 1 + H;
  localparam int FP        = 16 * RP;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b1;
  logic       ser_data, ser_clk, ser_latch, oe_n, frame_done;
  logic [3:0] row_sel;

  led_matrix_scan_if fif ();

  led_matrix_scan #(.CLK_DIV(D), .ROW_HOLD(H)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .frame_if   (fif),
    .ser_data   (ser_data),
    .ser_clk    (ser_clk),
    .ser_latch  (ser_latch),
    .row_sel    (row_sel),
    .oe_n       (oe_n),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: frame position (row, p = clock within the row period).
  bit           m_idle   = 1'b1;
  int           m_row    = 0;
  int           m_p      = 0;
  int           m_rowsel = 0;
  bit           m_pend   = 1'b0;
  logic [383:0] m_act    = '0;
  logic [383:0] m_shadow = '0;

  function automatic bit m_ready();
    if (rst_n !== 1'b1) return 1'b0;
`ifdef LMS_DOUBLE_BUFFER_EN
    return 1'b1;
`else
    return m_idle || (m_row == 15 && m_p > SHIFT_LEN);
`endif
  endfunction

  task automatic m_new_frame();
`ifdef LMS_DOUBLE_BUFFER_EN
    if (m_pend) m_act = m_shadow;
`endif
    m_pend = 1'b0;
  endtask

  initial forever begin
    bit hs;
    @(posedge clk or negedge rst_n);
    if (rst_n !== 1'b1) begin
      m_idle = 1'b1; m_row = 0; m_p = 0; m_rowsel = 0; m_pend = 1'b0;
      m_act = '0; m_shadow = '0;
    end else begin
      hs = (fif.frame_valid === 1'b1) && m_ready();
      if (m_idle) begin
        if (m_pend) begin
          m_idle = 1'b0; m_row = 0; m_p = 0;
          m_new_frame();
        end
      end else begin
        m_p++;
        if (m_p == RP) begin
          m_p   = 0;
          m_row = (m_row + 1) % 16;
          if (m_row == 0) m_new_frame();
        end
        if (m_p == SHIFT_LEN) m_rowsel = m_row;
      end
      if (hs) begin
`ifdef LMS_DOUBLE_BUFFER_EN
        m_shadow = fif.frame_data;
`else
        m_act = fif.frame_data;
`endif
        m_pend = 1'b1;
      end
    end
  end

  // Per-cycle comparison of every output against the model.
  initial forever begin
    bit shift;
    int h;
    @(negedge clk);
    shift = !m_idle && m_p < SHIFT_LEN;
    h     = m_p / D;
    chk("ser_clk",     ser_clk,   shift && (h % 2 == 1));
    chk("ser_data",    ser_data,  shift ? m_act[m_row * 24 + 23 - h / 2] : 1'b0);
    chk("ser_latch",   ser_latch, !m_idle && m_p == SHIFT_LEN);
    chk("oe_n",        oe_n,      !(!m_idle && m_p > SHIFT_LEN));
    chk("frame_done",  frame_done, !m_idle && m_row == 15 && m_p == RP - 1);
    chk("row_sel",     row_sel,   m_rowsel);
    chk("frame_ready", fif.frame_ready, m_ready());
  end

  // Literal timing: frame_done spacing and row_sel sequence at each latch.
  initial begin
    int cyc, last, prev;
    cyc = 0; last = -1; prev = 15;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst_n !== 1'b1) begin
        last = -1; prev = 15;
      end else begin
        if (frame_done === 1'b1) begin
          if (last >= 0) chk("done_gap", cyc - last, 848);
          last = cyc;
        end
        if (ser_latch === 1'b1) begin
          chk("row_seq", row_sel, (prev + 1) % 16);
          prev = (prev + 1) % 16;
        end
      end
    end
  end

  function automatic logic [383:0] rand_frame();
    logic [383:0] f;
    for (int i = 0; i < 12; i++) f[i*32 +: 32] = $urandom();
    return f;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push(input logic [383:0] d);
    bit done;
    done = 1'b0;
    @(negedge clk);
    fif.frame_data  = d;
    fif.frame_valid = 1'b1;
    for (int i = 0; i < 2 * FP && !done; i++) begin
      if (fif.frame_ready === 1'b1) done = 1'b1;
      else @(negedge clk);
    end
    chk("push_accept", done, 1);
    if (done) @(posedge clk);
    #1 fif.frame_valid = 1'b0;
  endtask

  task automatic wait_pos(input int r, input int p);
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < 2 * FP && !hit; i++) begin
      @(negedge clk);
      if (!m_idle && m_row == r && m_p == p) hit = 1'b1;
    end
    chk("wait_pos", hit, 1);
  endtask

  // Starting at the negedge of a row's first SHIFT clock, gather the 24 shifted bits.
  task automatic collect_row(output logic [23:0] bits);
    logic prev;
    prev = 1'b0;
    bits = '0;
    for (int i = 0; i < SHIFT_LEN; i++) begin
      if (i > 0) @(negedge clk);
      if (ser_clk === 1'b1 && prev === 1'b0) bits = {bits[22:0], ser_data};
      prev = ser_clk;
    end
  endtask

  initial begin
    logic [383:0] f0, fa, fb, fc;
    logic [23:0]  bits;
    int bad, latch_at, rises, ones, d24, oe_low, first_low, blocked, edges;
    logic prev_clk;
    bit ok;

    fif.frame_valid = 1'b0;
    fif.frame_data  = '0;
    #1 rst_n = 1'b0;
    #2;
    chk("rst_oe_n",    oe_n, 1);
    chk("rst_ser_clk", ser_clk, 0);
    chk("rst_row_sel", row_sel, 0);
    chk("rst_ready",   fif.frame_ready, 0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;

    // Idle with no frame offered.
    bad = 0;
    repeat (1000) begin
      @(negedge clk);
      if (oe_n !== 1'b1 || ser_clk !== 1'b0 || fif.frame_ready !== 1'b1) bad++;
    end
    chk("idle_hold", bad, 0);

    // Single lit LED at row 0, col 0.
    f0 = '0;
    f0[0] = 1'b1;
    push(f0);
    @(negedge clk);
    latch_at = 0; rises = 0; ones = 0; d24 = 0; oe_low = 0; first_low = 0; prev_clk = 1'b0;
    for (int k = 1; k <= RP; k++) begin
      @(negedge clk);
      if (ser_latch === 1'b1) latch_at = k;
      if (ser_clk === 1'b1 && prev_clk === 1'b0) begin
        rises++;
        if (ser_data === 1'b1) ones++;
        if (rises == 24) d24 = int'(ser_data);
      end
      prev_clk = ser_clk;
      if (oe_n === 1'b0) begin
        oe_low++;
        if (first_low == 0) first_low = k;
      end
    end
    chk("latch_clock",   latch_at, 49);
    chk("rise_count",    rises, 24);
    chk("ones_at_rises", ones, 1);
    chk("data_rise24",   d24, 1);
    chk("oe_low_clks",   oe_low, 4);
    chk("oe_first_low",  first_low, 50);
    tick(2 * FP);

`ifdef LMS_DOUBLE_BUFFER_EN
    fa = rand_frame();
    fb = rand_frame();
    fc = rand_frame();
    push(fa);
    wait_pos(0, 0);
    wait_pos(5, 0);
    push(fb);
    push(fc);
    wait_pos(6, 0);
    collect_row(bits);
    chk("row6_is_a", bits, fa[6*24 +: 24]);
    wait_pos(15, 0);
    collect_row(bits);
    chk("row15_is_a", bits, fa[15*24 +: 24]);
    wait_pos(0, 0);
    collect_row(bits);
    chk("row0_is_c", bits, fc[23:0]);
    tick(FP);
`else
    // frame_valid held from row 3 must stall until row 15 DISPLAY.
    fa = rand_frame();
    wait_pos(3, 0);
    fif.frame_data  = fa;
    fif.frame_valid = 1'b1;
    blocked = 0;
    ok = 1'b0;
    for (int i = 0; i < 2 * FP && !ok; i++) begin
      if (fif.frame_ready === 1'b1) ok = 1'b1;
      else begin
        blocked++;
        @(negedge clk);
      end
    end
    chk("ready_blocked", blocked, 685);
    chk("ready_row_sel", row_sel, 15);
    chk("ready_oe_n",    oe_n, 0);
    @(posedge clk);
    #1 fif.frame_valid = 1'b0;
    wait_pos(0, 0);
    collect_row(bits);
    chk("row0_new", bits, fa[23:0]);
    tick(FP);
`endif

    for (int n = 0; n < 4; n++) begin
      tick($urandom_range(0, 600));
      push(rand_frame());
    end
    tick(FP);

    // Async reset in the middle of row 7 SHIFT.
    wait_pos(7, 20);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_oe_n",       oe_n, 1);
    chk("arst_ser_clk",    ser_clk, 0);
    chk("arst_ser_latch",  ser_latch, 0);
    chk("arst_ser_data",   ser_data, 0);
    chk("arst_row_sel",    row_sel, 0);
    chk("arst_frame_done", frame_done, 0);
    edges = 0;
    repeat (3) begin
      @(negedge clk);
      if (ser_clk !== 1'b0) edges++;
    end
    chk("arst_no_ser_clk", edges, 0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    bad = 0;
    repeat (200) begin
      @(negedge clk);
      if (oe_n !== 1'b1 || ser_clk !== 1'b0 || ser_latch !== 1'b0) bad++;
    end
    chk("post_rst_idle", bad, 0);

    fb = rand_frame();
    push(fb);
    wait_pos(0, 0);
    collect_row(bits);
    chk("post_rst_row0", bits, fb[23:0]);
    tick(100);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
